// File: rtl/mod_inverse_engine.sv
// Iterative modular inverse (binary extended Euclid) with start/busy/done handshake.
// Produces inv = a^-1 mod n for odd n >= 3, or err for non-invertible / out-of-range operands.
module mod_inverse_engine #(
  parameter int WIDTH    = 512,
  parameter int ITER_MAX = 4 * WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] n,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] inv
);

  localparam int CW = $clog2(ITER_MAX + 1);
  localparam logic [CW-1:0] ITER_LIM = CW'(ITER_MAX);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a, r_n, r_u, r_v, r_x1, r_x2;
  logic [CW-1:0]    r_cnt;

  // Coefficient updates keep x1/x2 in [0, n-1]; one extra bit holds carry/borrow.
  logic [WIDTH:0]   w_x1_sum, w_x2_sum, w_x1_diff, w_x2_diff;
  logic [WIDTH-1:0] w_x1_half, w_x2_half, w_x1_sub, w_x2_sub;
  logic             w_bad;

  assign w_x1_sum  = {1'b0, r_x1} + {1'b0, r_n};
  assign w_x2_sum  = {1'b0, r_x2} + {1'b0, r_n};
  assign w_x1_half = r_x1[0] ? w_x1_sum[WIDTH:1] : {1'b0, r_x1[WIDTH-1:1]};
  assign w_x2_half = r_x2[0] ? w_x2_sum[WIDTH:1] : {1'b0, r_x2[WIDTH-1:1]};

  assign w_x1_diff = {1'b0, r_x1} - {1'b0, r_x2};
  assign w_x2_diff = {1'b0, r_x2} - {1'b0, r_x1};
  assign w_x1_sub  = w_x1_diff[WIDTH] ? w_x1_diff[WIDTH-1:0] + r_n : w_x1_diff[WIDTH-1:0];
  assign w_x2_sub  = w_x2_diff[WIDTH] ? w_x2_diff[WIDTH-1:0] + r_n : w_x2_diff[WIDTH-1:0];

  assign w_bad = ~r_n[0] | (r_n < WIDTH'(3)) | (r_a == '0) | (r_a >= r_n);

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      inv     <= '0;
      r_a     <= '0;
      r_n     <= '0;
      r_u     <= '0;
      r_v     <= '0;
      r_x1    <= '0;
      r_x2    <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_a     <= a;
            r_n     <= n;
            busy    <= 1'b1;
            err     <= 1'b0;
            r_state <= S_CHECK;
          end
        end

        S_CHECK: begin
          if (w_bad) begin
            err     <= 1'b1;
            inv     <= '0;
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_u     <= r_a;
            r_v     <= r_n;
            r_x1    <= WIDTH'(1);
            r_x2    <= '0;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end
        end

        S_RUN: begin
          r_cnt <= r_cnt + CW'(1);
          if (r_u == WIDTH'(1)) begin
            inv     <= r_x1;
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= S_DONE;
          end else if (r_v == WIDTH'(1)) begin
            inv     <= r_x2;
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= S_DONE;
          end else if (r_u == '0 || r_v == '0 || r_cnt == ITER_LIM) begin
            // gcd(a, n) > 1 drives one operand to zero before either reaches one.
            err     <= 1'b1;
            inv     <= '0;
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= S_DONE;
          end else if (!r_u[0]) begin
            r_u  <= r_u >> 1;
            r_x1 <= w_x1_half;
          end else if (!r_v[0]) begin
            r_v  <= r_v >> 1;
            r_x2 <= w_x2_half;
          end else if (r_u >= r_v) begin
            r_u  <= r_u - r_v;
            r_x1 <= w_x1_sub;
          end else begin
            r_v  <= r_v - r_u;
            r_x2 <= w_x2_sub;
          end
        end

        S_DONE: begin
          done    <= 1'b0;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_inverse_engine.sv
// Scoreboard bench for mod_inverse_engine at WIDTH=64: a driver queues expected
// results per request, a negedge monitor pops and compares on every done pulse.
module tb_mod_inverse_engine;

  localparam int W = 64;
  localparam logic [W-1:0] P    = 64'hFFFF_FFFF_FFFF_FFC5; // 2^64 - 59, prime
  localparam logic [W-1:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [W-1:0] a, n;
  logic         busy, done, err;
  logic [W-1:0] inv;

  mod_inverse_engine #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .n     (n),
    .busy  (busy),
    .done  (done),
    .err   (err),
    .inv   (inv)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic         e;
    logic [W-1:0] v;
    int           issue;
    int           lat;   // exact latency, or -1 to check only the upper bound
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    int   lat;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e   = sb.pop_front();
        lat = cyc - e.issue;
        check("err", err, e.e);
        check("inv", inv, e.v);
        if (e.lat >= 0) check("latency", lat, e.lat);
        else            check("latency_bound", (lat <= 2 * W + 4), 1);
      end
    end
  end

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tn, input logic ee,
                        input logic [W-1:0] ev, input int lat, input bit noisy);
    int gap  = 0;
    bit seen = 0;
    @(negedge clk);
    a     = ta;
    n     = tn;
    start = 1'b1;
    sb.push_back('{ee, ev, cyc, lat});
    for (int k = 0; k < 4 * W; k++) begin
      @(negedge clk);
      start = noisy;
      if (noisy) begin
        a = {$urandom, $urandom};
        n = {$urandom, $urandom};
      end
      if (done === 1'b1) begin
        seen = 1;
        break;
      end
      if (busy !== 1'b1) gap++;
    end
    check("done_seen", seen, 1);
    check("busy_gap", gap, 0);
    @(negedge clk);
    start = 1'b0;
    check("idle_busy", busy, 0);
    check("inv_hold", inv, ev);
    check("err_hold", err, ee);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    n     = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_inv", inv, 0);
    rst = 1'b0;

    run_op(3,  7,  0, 5,  6, 0);
    run_op(53, 61, 0, 38, 7, 0);
    run_op(6,  9,  1, 0,  7, 0);   // gcd = 3
    run_op(0,  7,  1, 0,  2, 0);
    run_op(3,  8,  1, 0,  2, 0);   // even modulus
    run_op(9,  7,  1, 0,  2, 0);   // a >= n
    run_op(7,  7,  1, 0,  2, 0);
    run_op(1,  1,  1, 0,  2, 0);   // n < 3
    run_op(1,  7,  0, 1,  3, 0);   // fastest path
    run_op(53, 61, 0, 38, 7, 1);   // start pulses and operand churn while busy

    // Abort a long operation in its 5th RUN cycle.
    @(negedge clk);
    a     = 3;
    n     = P;
    start = 1'b1;
    sb.push_back('{1'b0, (P + 1) / 3, cyc, -1});
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_err", err, 0);
    check("abort_inv", inv, 0);
    repeat (2) @(negedge clk);

    run_op(2,     11,   0, 6,           4,  0);
    run_op(2,     P,    0, (P + 1) / 2, -1, 0);
    run_op(3,     P,    0, (P + 1) / 3, -1, 0);
    run_op(P - 1, P,    0, P - 1,       -1, 0);
    run_op(2,     ALL1, 0, 64'h8000_0000_0000_0000, -1, 0);

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

endmodule

// File: doc/mod_inverse_engine.md
Name: mod_inverse_engine

Overview:
- Parametrised iterative modular-inverse unit. Computes inv = a^-1 mod n for odd n using the binary extended Euclidean algorithm: shift, add and subtract only, no divider.
- Successor to the fixed-512-bit qinv path in the CRT decryption datapath. Adds a start/busy/done handshake, a synchronous reset, bounded latency and an explicit non-invertible error flag.
- Feeds q^-1 mod p to the CRT recombination stage.

Parameters:
- WIDTH, 512, operand and result width in bits (>= 4).
- ITER_MAX, 4*WIDTH, RUN-cycle watchdog limit; reaching it flags err.

Ports:
- clk    input   1      rising-edge clock
- rst    input   1      synchronous, active-high reset
- start  input   1      request; sampled only in IDLE
- a      input   WIDTH  value to invert; captured on an accepted start
- n      input   WIDTH  modulus, must be odd; captured on an accepted start
- busy   output  1      high in CHECK and RUN
- done   output  1      one-cycle pulse when a result or error is available
- err    output  1      valid with done; held until the next accepted start
- inv    output  WIDTH  inverse in [1, n-1]; valid with done and err=0; held until the next accepted start

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - busy=0, done=0, err=0, inv=0.
  - Internal registers u, v, x1, x2 and the iteration counter are cleared.
  - Reset has priority over start and aborts any operation in progress with no done pulse.
- States: IDLE, CHECK, RUN, DONE.
- IDLE:
  - start=1 captures a and n, then moves to CHECK.
  - Sets busy=1 next cycle and clears err.
- CHECK (one cycle):
  - If n even, n<3, a==0 or a>=n: set err=1, go to DONE.
  - Otherwise load u=a, v=n, x1=1, x2=0, cnt=0, go to RUN.
- RUN: one action per cycle, evaluated in this priority order:
  1. u==1: inv=x1, go to DONE.
  2. v==1: inv=x2, go to DONE.
  3. u==0, v==0 or cnt==ITER_MAX: err=1, go to DONE. This covers gcd(a,n)>1.
  4. u even: u=u>>1; x1 = x1 even ? x1>>1 : (x1+n)>>1.
  5. v even: v=v>>1; x2 halved the same way.
  6. u>=v: u=u-v; x1 = x1-x2, adding n if negative.
  7. Otherwise: v=v-u; x2 = x2-x1, adding n if negative.
  - cnt increments on every RUN cycle.
- Arithmetic widths:
  - x1+n and the subtractions use WIDTH+1 bits internally.
  - x1 and x2 always stay in [0, n-1].
  - u and v never exceed n.
- DONE (one cycle):
  - done=1, busy=0, then return to IDLE.
  - inv and err hold their values after DONE.
  - On the error path, inv is driven to 0.
- Latency: start to done = 2 + RUN cycles, with RUN cycles <= 2*WIDTH+2 for valid inputs. The fastest case is a=1: 3 cycles.
- start while busy (CHECK/RUN/DONE): ignored; no queueing.
- start in the same cycle as done: ignored; start must be reasserted in IDLE.
- a and n may change after capture without affecting the operation in progress.
- rst during RUN: abort on the next edge; a start on the following cycle behaves as from a fresh reset.

Test Plan:
- a=3, n=7 -> done after <= 2*WIDTH+4 cycles with inv=5, err=0; busy high from the cycle after start until done.
- WIDTH=8: a=53, n=61 (the q^-1 mod p case) -> inv=38, err=0. Checks 53*38 mod 61 = 1.
- a=6, n=9 (gcd=3) -> done with err=1, inv=0. Also a=0, n=7 -> err=1 exactly 2 cycles after start.
- n=8 (even) and a=9, n=7 (a>=n) -> err=1 from CHECK, done 2 cycles after start. Then a=1, n=7 -> inv=1, done 3 cycles after start.
- Pulse start repeatedly while busy, and change a/n mid-run -> only the first request completes, with a result matching the originally captured operands.
- Assert rst in the 5th RUN cycle -> next cycle busy=0, done=0, err=0, inv=0, no done pulse. Then a=2, n=11 -> inv=6.
- Randomised at WIDTH=64 against a reference model, including prime moduli up to 2^64-59 -> inv*a mod n == 1 and cycle count <= 2*WIDTH+4.
